// File: rtl/mem_arbiter_if.sv
// Requester-side bus of the ram arbiter: one instance per requester (CPU, DMA).
// The requester uses the master modport, the arbiter the slave modport.
interface mem_arbiter_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the single-port 512x32 ram: one-cycle strobes, registered rdata, one-cycle ack.
// Optional macro MEM_ARB_RR_EN selects round-robin tie-breaking instead of fixed CPU priority.
module mem_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  mem_arbiter_if.slave      cpu,
  mem_arbiter_if.slave      dma,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, ACK} state_t;

  state_t            state;
  logic              win_dma;
  logic              lat_we;
  logic              grant_dma;
  logic              cpu_ack_q;
  logic              dma_ack_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] dma_rdata_q;

`ifdef MEM_ARB_RR_EN
  // last_grant: 1 = CPU was granted last; reset value 0 means DMA, so CPU wins the first tie.
  logic last_grant;
  always_comb grant_dma = dma.req & (~cpu.req | last_grant);
`else
  always_comb grant_dma = dma.req & ~cpu.req;
`endif

  assign cpu.ack   = cpu_ack_q;
  assign dma.ack   = dma_ack_q;
  assign cpu.rdata = cpu_rdata_q;
  assign dma.rdata = dma_rdata_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      win_dma     <= 1'b0;
      lat_we      <= 1'b0;
      ram_read    <= 1'b0;
      ram_write   <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      busy        <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_grant  <= 1'b0;
`endif
    end else begin
      // NOTE: pulse outputs default low here so every state only states when they fire; a single-cycle strobe needs no explicit clear.
      ram_read  <= 1'b0;
      ram_write <= 1'b0;
      cpu_ack_q <= 1'b0;
      dma_ack_q <= 1'b0;

      case (state)
        IDLE: begin
          if (cpu.req || dma.req) begin
            win_dma   <= grant_dma;
            lat_we    <= grant_dma ? dma.we : cpu.we;
            ram_addr  <= grant_dma ? dma.addr : cpu.addr;
            ram_wdata <= grant_dma ? dma.wdata : cpu.wdata;
            ram_write <= grant_dma ? dma.we : cpu.we;
            ram_read  <= grant_dma ? ~dma.we : ~cpu.we;
            busy      <= 1'b1;
            state     <= ISSUE;
`ifdef MEM_ARB_RR_EN
            last_grant <= ~grant_dma;
`endif
          end
        end
        ISSUE: begin
          if (lat_we) begin
            cpu_ack_q <= ~win_dma;
            dma_ack_q <= win_dma;
            state     <= ACK;
          end else begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          // ram_rdata became valid at the edge that closed ISSUE; only the winner's copy moves.
          if (win_dma) dma_rdata_q <= ram_rdata;
          else         cpu_rdata_q <= ram_rdata;
          cpu_ack_q <= ~win_dma;
          dma_ack_q <= win_dma;
          state     <= ACK;
        end
        ACK: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
